// File: rtl/sync_bus_pkg.sv
// Shared definitions for the sync_bus responder.
//   state_e          : transaction FSM states (IDLE -> WAIT -> GRANT -> IDLE)
//   DEF_ADDR_W       : default address width
//   DEF_DATA_W       : default data width
//   TXN_CNT_W        : width of the completed-transaction counter
package sync_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int TXN_CNT_W  = 16;

endpackage

// File: rtl/sync_bus_regfile.sv
// DEPTH x DATA_W register array for sync_bus.
//   clk      : clock, posedge
//   rst_n    : synchronous active-low clear of every entry
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : write value
//   rd_addr  : combinational read index
//   rd_data  : combinational read value
module sync_bus_regfile
    import sync_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage: clear has priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_bus.sv
// Single-target synchronous bus responder. A request seen in IDLE is
// captured and granted exactly GNT_DELAY cycles later with a one-cycle
// gnt pulse; reads present data on rdata/rdata_oe in that grant cycle,
// writes commit to the register array at the grant's closing edge.
//   clk, rst_n : clock and synchronous active-low reset
//   req, we, addr, wdata : master request, captured together in IDLE
//   gnt        : one-cycle completion pulse
//   rdata, rdata_oe : read data lane and its drive enable (grant-read only)
//   busy       : transaction in flight
//   txn_count  : completed transactions, wrapping
module sync_bus
    import sync_bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 2**ADDR_W,
    parameter int GNT_DELAY = 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 gnt,
    output logic [DATA_W-1:0]    rdata,
    output logic                 rdata_oe,
    output logic                 busy,
    output logic [TXN_CNT_W-1:0] txn_count
);

    generate
        if (GNT_DELAY < 1 || GNT_DELAY > 3) begin : g_bad_delay
            $error("sync_bus: GNT_DELAY must be within 1..3");
        end
        if (DEPTH != 2**ADDR_W) begin : g_bad_depth
            $error("sync_bus: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    // WAIT lasts GNT_DELAY-1 cycles; a delay of 1 skips WAIT entirely.
    localparam logic [1:0] DELAY_LOAD  = 2'(GNT_DELAY - 1);
    localparam state_e     FIRST_STATE = (GNT_DELAY == 1) ? GRANT : WAIT;

    state_e              state_r, state_nxt_s;
    logic [1:0]          cnt_r, cnt_nxt_s;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                gnt_r, rdata_oe_r, busy_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [TXN_CNT_W-1:0] txn_cnt_r;

    logic                accept_s;
    logic                nxt_we_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                wr_en_s;

    // Next-state and delay-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nxt_s = FIRST_STATE;
                    cnt_nxt_s   = DELAY_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 2'd1) begin
                    state_nxt_s = GRANT;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    cnt_nxt_s   = cnt_r - 2'd1;
                end
            end
            GRANT:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs are registered one edge early, so the read address and
    // direction must come from the live inputs when IDLE jumps to GRANT.
    always_comb begin
        accept_s = (state_r == IDLE) && req;
        if (accept_s) begin
            nxt_we_s  = we;
            rd_addr_s = addr;
        end else begin
            nxt_we_s  = we_r;
            rd_addr_s = addr_r;
        end
        wr_en_s = (state_r == GRANT) && we_r;
    end

    // FSM state, capture registers, registered outputs and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 2'd0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            gnt_r      <= 1'b0;
            busy_r     <= 1'b0;
            rdata_r    <= '0;
            rdata_oe_r <= 1'b0;
            txn_cnt_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                we_r    <= we;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
            gnt_r  <= (state_nxt_s == GRANT);
            busy_r <= (state_nxt_s != IDLE);
            if ((state_nxt_s == GRANT) && !nxt_we_s) begin
                rdata_r    <= rd_data_s;
                rdata_oe_r <= 1'b1;
            end else begin
                rdata_r    <= '0;
                rdata_oe_r <= 1'b0;
            end
            if (state_r == GRANT) begin
                txn_cnt_r <= txn_cnt_r + TXN_CNT_W'(1'b1);
            end
        end
    end

    sync_bus_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr (addr_r),
        .wr_data (wdata_r),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    assign gnt       = gnt_r;
    assign rdata     = rdata_r;
    assign rdata_oe  = rdata_oe_r;
    assign busy      = busy_r;
    assign txn_count = txn_cnt_r;

endmodule

// File: tb/tb_sync_bus.sv
// Bench for sync_bus: three instances (GNT_DELAY 1/2/3) share one
// stimulus stream; the delay-2 instance carries the functional checks.
module tb_sync_bus;

    logic        clk = 1'b0;
    logic        rst_n, req, we;
    logic [7:0]  addr, wdata;

    logic        gnt1, gnt2, gnt3;
    logic [7:0]  rdata1, rdata2, rdata3;
    logic        oe1, oe2, oe3;
    logic        busy1, busy2, busy3;
    logic [15:0] cnt1, cnt2, cnt3;

    sync_bus #(.GNT_DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt1), .rdata(rdata1), .rdata_oe(oe1), .busy(busy1), .txn_count(cnt1));
    sync_bus #(.GNT_DELAY(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt2), .rdata(rdata2), .rdata_oe(oe2), .busy(busy2), .txn_count(cnt2));
    sync_bus #(.GNT_DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt3), .rdata(rdata3), .rdata_oe(oe3), .busy(busy3), .txn_count(cnt3));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_oe;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One request pulse on the shared bus; reports delay-2 instance latency
    // (ticks from accepting edge, 1 = first cycle after it) and grant data.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output logic oe);
        lat = -1;
        rd  = 8'h00;
        oe  = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        // Dropped request and scrambled fields must not affect the transaction.
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) check("busy_in_flight", 32'(busy2), 32'd1);
            if (gnt2) begin
                lat = c;
                rd  = rdata2;
                oe  = oe2;
                break;
            end
            check("oe_outside_grant", 32'(oe2), 32'd0);
            tick();
        end
        tick();
    endtask

    int          lat;
    logic [7:0]  rd;
    logic        oe;
    int          gt[4];
    int          ng;
    logic [15:0] exp_cnt;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 16'd1};
        vecs[1] = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 16'd2};
        vecs[2] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, 16'd3};
        vecs[3] = '{1'b1, 8'h7F, 8'h3C, 8'h00, 1'b0, 16'd4};
        vecs[4] = '{1'b0, 8'h7F, 8'h00, 8'h3C, 1'b1, 16'd5};
        vecs[5] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 16'd6};
        vecs[6] = '{1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0, 16'd7};
        vecs[7] = '{1'b0, 8'hFF, 8'h00, 8'hC3, 1'b1, 16'd8};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 16'd9};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_gnt", 32'(gnt2), 32'd0);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_rdata", 32'(rdata2), 32'd0);
        check("rst_oe", 32'(oe2), 32'd0);
        check("rst_cnt", 32'(cnt2), 32'd0);
        tick();

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, oe);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_oe", i), 32'(oe), 32'(vecs[i].exp_oe));
            check($sformatf("vec%0d_cnt", i), 32'(cnt2), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_idle_oe", i), 32'(oe2), 32'd0);
        end
        exp_cnt = 16'd9;
        for (int k = 0; k < 4; k++) tick();

        // Held request: four writes, grants spaced GNT_DELAY+1 apart.
        for (int i = 0; i < 4; i++) gt[i] = -1;
        ng = 0;
        req = 1'b1; we = 1'b1; addr = 8'h00; wdata = 8'h11;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (gnt2) begin
                if (ng < 4) gt[ng] = t;
                ng++;
                if (ng >= 4) begin
                    req = 1'b0;
                end else begin
                    addr  = 8'(ng);
                    wdata = 8'(8'h11 * (ng + 1));
                end
            end
        end
        check("held_gnt_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("held_gnt%0d_time", i), 32'(gt[i]), 32'(2 + 3 * i));
        exp_cnt = exp_cnt + 16'd4;
        check("held_cnt", 32'(cnt2), 32'(exp_cnt));
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, 8'(i), 8'h00, lat, rd, oe);
            check($sformatf("held_rb%0d", i), 32'(rd), 32'(8'h11 * (i + 1)));
            exp_cnt = exp_cnt + 16'd1;
        end

        // Write with req dropped in WAIT still completes; read back.
        do_txn(1'b1, 8'h20, 8'hFF, lat, rd, oe);
        check("drop_latency", 32'(lat), 32'd2);
        do_txn(1'b0, 8'h20, 8'h00, lat, rd, oe);
        check("drop_rb", 32'(rd), 32'hFF);
        exp_cnt = exp_cnt + 16'd2;
        check("drop_cnt", 32'(cnt2), 32'(exp_cnt));

        // 20 isolated requests to addr 0/1, all three delays observed.
        for (int k = 0; k < 6; k++) tick();
        for (int r = 0; r < 20; r++) begin
            req = 1'b1; we = 1'($urandom_range(1, 0));
            addr = 8'($urandom_range(1, 0)); wdata = 8'($urandom_range(255, 0));
            tick();
            req = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                check($sformatf("rnd%0d_c%0d_gnt_d1", r, c), 32'(gnt1), 32'(c == 1));
                check($sformatf("rnd%0d_c%0d_gnt_d2", r, c), 32'(gnt2), 32'(c == 2));
                check($sformatf("rnd%0d_c%0d_gnt_d3", r, c), 32'(gnt3), 32'(c == 3));
                tick();
            end
        end

        // Reset during WAIT aborts the write.
        req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 8'h5A;
        tick();
        req = 1'b0;
        check("abort_busy_pre", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_gnt", 32'(gnt2), 32'd0);
        check("abort_busy", 32'(busy2), 32'd0);
        check("abort_cnt", 32'(cnt2), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_no_gnt%0d", c), 32'(gnt2), 32'd0);
        end
        do_txn(1'b0, 8'h30, 8'h00, lat, rd, oe);
        check("abort_rb", 32'(rd), 32'h00);
        check("abort_rb_oe", 32'(oe), 32'd1);
        check("abort_rb_cnt", 32'(cnt2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_bus.md
Name: sync_bus

Overview:
- Synchronous single-target bus responder (device-under-test side of the req/gnt/addr/data bus).
- Accepts requests from a clocked testbench or master and grants each one a fixed 1–3 cycles later.
- Performs an 8-bit read or write into an internal register array.
- The bidirectional bus data lane is split into a write-data input and a read-data output with output-enable; the top-level tristate is built outside this block.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- DEPTH, 256, register array entries (2**ADDR_W).
- GNT_DELAY, 2, cycles from request acceptance to grant. Legal range 1..3; an out-of-range value is an elaboration error.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- req  input  1  request from master, sampled in IDLE only.
- we  input  1  1 = write, 0 = read; captured with req.
- addr  input  ADDR_W  target address; captured with req.
- wdata  input  DATA_W  write data (master side of data lane); captured with req.
- gnt  output  1  one-cycle grant/completion pulse.
- rdata  output  DATA_W  read data (DUT side of data lane).
- rdata_oe  output  1  high when rdata must drive the shared data lane.
- busy  output  1  transaction in flight (state != IDLE).
- txn_count  output  16  completed-transaction counter, wraps at 0xFFFF->0.

Behaviour:
- Reset (rst_n low at a posedge):
  - state = IDLE.
  - gnt, rdata_oe, busy = 0; rdata = 0; txn_count = 0.
  - All DEPTH array entries cleared to 0.
  - Reset takes priority over every other event.
- State machine: IDLE -> WAIT -> GRANT -> IDLE.
- IDLE:
  - If req = 1 at posedge N: capture we/addr/wdata, load delay counter, assert busy.
  - Go to WAIT, or directly to GRANT if GNT_DELAY = 1.
- WAIT:
  - Count down; req, we, addr and wdata are ignored.
  - Transitions to GRANT so that gnt is sampled high at posedge N+GNT_DELAY. Latency is exactly GNT_DELAY cycles, giving req ##[1:3] gnt.
- GRANT (one cycle):
  - gnt = 1 and busy = 1.
  - Read: rdata = array[captured addr] and rdata_oe = 1 in this same cycle.
  - Write: rdata_oe = 0; array[captured addr] <= captured wdata at the closing posedge.
  - txn_count increments at the closing posedge.
  - Next state is IDLE.
- Back-to-back requests:
  - req is not sampled during GRANT.
  - req held high produces one transaction per GNT_DELAY+1 cycles.
  - The new request is accepted in the IDLE cycle after GRANT.
- Req dropped during WAIT: the transaction still completes; requests are non-cancellable.
- Read-after-write: a read of an address written by the immediately preceding transaction returns the new value.
- rdata outside GRANT-read cycles = 0; rdata_oe = 0 outside GRANT-read.
- Reset mid-transaction: the transaction is aborted; no array write, no gnt, no counter increment.
- Address width equals array index width, so no out-of-range address exists.

Decomposition:
- Package sync_bus_pkg:
  - state enum (IDLE, WAIT, GRANT);
  - default ADDR_W/DATA_W constants;
  - txn_count width constant (16).
- One sub-module, sync_bus_regfile:
  - DEPTH x DATA_W array with synchronous clear, one write port and one combinational read port.
  - Instantiated once by sync_bus, which holds the FSM, capture registers, delay counter and counter.

Test Plan:
- Reset, then read addr 0x10 with GNT_DELAY=2 -> gnt high exactly 2 cycles after req sampled; rdata = 0x00, rdata_oe = 1 in the gnt cycle only; txn_count = 1.
- Write 0x10 <- 0xA5, then read 0x10 -> second gnt cycle shows rdata = 0xA5; txn_count = 2; rdata_oe = 0 during the write grant.
- Elaborate with GNT_DELAY=1 and GNT_DELAY=3; issue 20 requests to random addresses 0/1 -> every gnt is exactly 1 (resp. 3) cycles after acceptance; no gnt without a request.
- Hold req = 1 continuously for 4 writes to 0x00..0x03 with data 0x11..0x44 -> 4 gnt pulses spaced GNT_DELAY+1 cycles apart; read-back returns 0x11/0x22/0x33/0x44.
- Accept a write 0x20 <- 0xFF, drop req in the WAIT cycle -> gnt still occurs; a later read of 0x20 = 0xFF.
- Accept a write 0x30 <- 0x5A, assert rst_n = 0 during WAIT -> no gnt; busy = 0 and txn_count = 0 after reset; read of 0x30 = 0x00.
